bt_cmd_scheduler: RTL
=====================

# bt_cmd_scheduler

Shares the single Bluetooth UART byte transmitter between three command sources: human sensor, ultrasonic obstacle logic, and the manual key panel. Each source presents a 3-bit car command. The block detects changes, arbitrates round-robin among pending sources and sends a two-byte frame per grant: a channel tag, then the command's ASCII character. It sits between the controller-side command logic and the 9600-baud byte transmitter. A periodic refresh re-sends the current commands so the car side recovers from lost bytes.

## Interface
- GAP_CYCLES, 1000: idle `inclk` cycles enforced after each frame; 0 means no gap.
- REFRESH_CYCLES, 50_000_000: period of the forced re-send of all valid channels; 0 disables refresh.
- inclk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- req_valid  in  3  per-channel: the code is meaningful (bit0 = sensor, bit1 = ultrasonic, bit2 = keys).
- req_code  in  9  three 3-bit codes; channel n occupies [3n+2:3n].
- tx_busy  in  1  byte transmitter busy, from the same clock domain.
- tx_start  out  1  one-cycle strobe: transmit tx_byte.
- tx_byte  out  8  byte to transmit.
- grant  out  3  one-hot; the channel owning the current frame.
- frame_done  out  1  one-cycle pulse when a frame completes, after the gap.

## Operation
- **Command mapping** (code→byte):
  - 000→0x30 '0', 001→0x31 '1', 010→0x32 '2', 011→0x57 'W'
  - 100→0x53 'S', 101→0x41 'A', 110→0x44 'D', 111→0x42 'B'
- **Tag byte:** 0x61 + n ('a', 'b', 'c').
- **Per-channel registers:** last_code[2:0] and pending.
  - Set pending and load last_code when req_valid[n]=1 and either req_code[n] ≠ last_code[n] or the channel was invalid on the previous cycle.
  - If a set and a grant-clear of pending occur in the same cycle, the set wins.
  - An invalid channel never becomes pending; its existing pending stays set.
- **Refresh:** a counter runs 0..REFRESH_CYCLES−1. On wrap, pending is set for every channel with req_valid=1.
- **Arbitration:** round-robin. The search starts at last_grant+1 mod 3. last_grant resets to 2, so channel 0 is favoured first.
- **FSM states:**
  - IDLE: if any pending and tx_busy=0, grant the chosen channel. In the same cycle, clear its pending, snapshot the code, and go to TAG.
  - TAG: tx_byte=tag, tx_start=1 → TAG_HI.
  - TAG_HI: wait tx_busy=1 → TAG_LO.
  - TAG_LO: wait tx_busy=0 → CMD.
  - CMD: tx_byte=mapped snapshot, tx_start=1 → CMD_HI.
  - CMD_HI: wait tx_busy=1 → CMD_LO.
  - CMD_LO: wait tx_busy=0 → GAP.
  - GAP: count GAP_CYCLES. At the end, pulse frame_done, clear grant, → IDLE.
- **Snapshot:** the frame always carries the code snapshotted at grant. A code change during a frame re-pends that channel for a later frame.
- **No timeout:** a transmitter that never raises busy stalls the FSM in *_HI until reset.

## Timing
- **Reset values:** tx_start=0, tx_byte=0x00, grant=000, frame_done=0, all pending=0, all last_code=000, refresh counter=0, FSM=IDLE.
- **Reset mid-frame:** all outputs take their reset values immediately (asynchronous). The transmitter shares rst_n.
- **Detection latency:** a code change sampled at edge k sets pending at edge k+1.
- **Grant latency:** IDLE grants at edge k+2. TAG drives tx_start during cycle k+2..k+3.
- **tx_start:** never high for two consecutive cycles. Never high while tx_busy=1.
- **grant:** held from the grant edge through the end of GAP.
- **Minimum frame length:** 2 + 2×(transmitter byte time) + GAP_CYCLES + 4 cycles.
- **Refresh wrap during a frame:** sets pending only; the current frame is unaffected.

## Test plan
- **Single change.** After reset, ch0 valid with code 011.
  - Bytes 0x61 then 0x57.
  - grant=001; frame_done once; no further frames.
- **Three simultaneous changes.** ch0=001, ch1=100, ch2=110, all in one cycle.
  - Frames in order a/'1', b/'S', c/'D'.
- **Fairness.** ch0 changes again during the ch0 frame while ch1 is pending.
  - Next frame is b. The ch0 frame follows with the newest code.
- **Snapshot.** ch1 code changes 101→111 after its grant.
  - Current frame sends 'A'; the next ch1 frame sends 'B'.
- **Refresh.** REFRESH_CYCLES=200, codes static, ch2 invalid.
  - Frames a and b repeat every 200 cycles; c is never sent.
- **Async reset mid-frame.** Assert rst_n=0 in CMD_HI.
  - tx_start=0 and grant=000 without waiting for a clock edge.
  - After release, with valid codes steady: one frame per valid channel. This holds because the channels read as newly valid.

Source files
------------

// File: rtl/bt_cmd_scheduler.sv
// rtl/bt_cmd_scheduler.sv - round-robin scheduler sharing one UART byte transmitter among three command channels
//
// Purpose: watches three 3-bit car command channels, marks a channel pending when
// its code changes (or it becomes valid, or the refresh timer wraps), and sends a
// two-byte frame per grant: channel tag ('a'+n) then the command's ASCII character.
//
// Ports:
//   inclk       system clock
//   rst_n       asynchronous active-low reset
//   req_valid   per-channel valid (bit0 sensor, bit1 ultrasonic, bit2 keys)
//   req_code    three 3-bit codes, channel n at [3n+2:3n]
//   tx_busy     byte transmitter busy
//   tx_start    one-cycle strobe to transmit tx_byte
//   tx_byte     byte to transmit
//   grant       one-hot owner of the current frame
//   frame_done  one-cycle pulse at the end of a frame's gap
module bt_cmd_scheduler #(
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned REFRESH_CYCLES = 50_000_000
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic [2:0] req_valid,
    input  logic [8:0] req_code,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic [2:0] grant,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_TAG_HI, S_TAG_LO, S_CMD, S_CMD_HI, S_CMD_LO, S_GAP
    } state_e;

    localparam logic [31:0] REFRESH_LAST = (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES);

    state_e          state_q, state_d;
    logic [2:0]      valid_q, valid_prev_q;
    logic [2:0][2:0] code_q, last_code_q, last_code_d;
    logic [2:0]      pending_q, pending_d;
    logic [2:0]      grant_q, snap_q;
    logic [1:0]      last_grant_q, grant_idx_q;
    logic [1:0]      cand0, cand1, cand2, pick;
    logic [31:0]     gap_q, gap_d, refresh_q, refresh_d;
    logic            refresh_wrap, grant_now;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    function automatic logic [7:0] cmd_ascii(input logic [2:0] code);
        case (code)
            3'd0:    return 8'h30;
            3'd1:    return 8'h31;
            3'd2:    return 8'h32;
            3'd3:    return 8'h57;
            3'd4:    return 8'h53;
            3'd5:    return 8'h41;
            3'd6:    return 8'h44;
            default: return 8'h42;
        endcase
    endfunction

    // Refresh timer; a zero period leaves it parked at 0 and never wrapping.
    assign refresh_wrap = (REFRESH_CYCLES != 0) && (refresh_q == REFRESH_LAST);
    assign refresh_d    = (refresh_wrap || REFRESH_CYCLES == 0) ? 32'd0 : refresh_q + 32'd1;

    // Round-robin search order starts one past the last granted channel.
    assign cand0 = next_ch(last_grant_q);
    assign cand1 = next_ch(cand0);
    assign cand2 = next_ch(cand1);
    assign pick  = pending_q[cand0] ? cand0 : (pending_q[cand1] ? cand1 : cand2);

    // Detection works on the registered inputs, so a change sampled at one edge
    // sets pending on the next. A set is applied after the grant clear so it wins.
    always_comb begin
        pending_d   = pending_q;
        last_code_d = last_code_q;
        for (int n = 0; n < 3; n++) begin
            if (grant_now && pick == 2'(n)) begin
                pending_d[n] = 1'b0;
            end
            if (valid_q[n] && (!valid_prev_q[n] || code_q[n] != last_code_q[n] || refresh_wrap)) begin
                pending_d[n]   = 1'b1;
                last_code_d[n] = code_q[n];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        grant_now  = 1'b0;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pending_q && !tx_busy) begin
                    grant_now = 1'b1;
                    state_d   = S_TAG;
                end
            end
            S_TAG: begin
                tx_byte = 8'h61 + {6'd0, grant_idx_q};
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_TAG_HI;
                end
            end
            S_TAG_HI: if (tx_busy)  state_d = S_TAG_LO;
            S_TAG_LO: if (!tx_busy) state_d = S_CMD;
            S_CMD: begin
                tx_byte = cmd_ascii(snap_q);
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_CMD_HI;
                end
            end
            S_CMD_HI: if (tx_busy) state_d = S_CMD_LO;
            S_CMD_LO: begin
                if (!tx_busy) begin
                    gap_d   = 32'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            valid_prev_q <= '0;
            code_q       <= '0;
            last_code_q  <= '0;
            pending_q    <= '0;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            snap_q       <= '0;
            last_grant_q <= 2'd2;
            gap_q        <= '0;
            refresh_q    <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= req_valid;
            valid_prev_q <= valid_q;
            code_q       <= req_code;
            last_code_q  <= last_code_d;
            pending_q    <= pending_d;
            gap_q        <= gap_d;
            refresh_q    <= refresh_d;
            if (grant_now) begin
                grant_q      <= 3'b001 << pick;
                grant_idx_q  <= pick;
                snap_q       <= last_code_q[pick];
                last_grant_q <= pick;
            end else if (frame_done) begin
                grant_q <= '0;
            end
        end
    end

    assign grant = grant_q;

endmodule
